// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and constants for the instruction/data memory port arbiter.
// Lives alongside riscv_defines; the widths below mirror RISCV_ADDR_WIDTH and
// RISCV_WORD_WIDTH.
package mem_port_arbiter_pkg;

  // Arbiter FSM state; BUSY_I and BUSY_D also tell you who owns the port.
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2
  } arb_state_e;

  // Requester identity, used by the round-robin history bit.
  typedef enum logic {
    ARB_OWNER_I = 1'b0,
    ARB_OWNER_D = 1'b1
  } arb_owner_e;

  localparam int ARB_ADDR_WIDTH      = 32;
  localparam int ARB_DATA_WIDTH      = 32;
  localparam int ARB_DEFAULT_TIMEOUT = 255;

  // Width of the wait counter; never zero so TIMEOUT=0 still elaborates.
  function automatic int arbCountWidth(input int timeout);
    if (timeout < 1) begin
      return 1;
    end
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of every handshake/bus signal around the arbiter. Signal names keep
// the arbiter's point of view (_i enters the arbiter, _o leaves it).
// slave  : the arbiter itself.
// master : the environment (fetch unit, LSU and memory together).
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                  imem_valid_i;
  logic [ADDR_WIDTH-1:0] imem_addr_i;
  logic                  imem_ready_o;
  logic                  imem_err_o;
  logic [DATA_WIDTH-1:0] imem_rdata_o;

  logic                  dmem_valid_i;
  logic [ADDR_WIDTH-1:0] dmem_addr_i;
  logic [DATA_WIDTH-1:0] dmem_wdata_i;
  logic [3:0]            dmem_we_i;
  logic                  dmem_ready_o;
  logic                  dmem_err_o;
  logic [DATA_WIDTH-1:0] dmem_rdata_o;

  logic                  mem_valid_o;
  logic                  mem_ready_i;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [3:0]            mem_we_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  modport slave (
    input  imem_valid_i, imem_addr_i,
    output imem_ready_o, imem_err_o, imem_rdata_o,
    input  dmem_valid_i, dmem_addr_i, dmem_wdata_i, dmem_we_i,
    output dmem_ready_o, dmem_err_o, dmem_rdata_o,
    output mem_valid_o, mem_addr_o, mem_wdata_o, mem_we_o,
    input  mem_ready_i, mem_rdata_i
  );

  modport master (
    output imem_valid_i, imem_addr_i,
    input  imem_ready_o, imem_err_o, imem_rdata_o,
    output dmem_valid_i, dmem_addr_i, dmem_wdata_i, dmem_we_i,
    input  dmem_ready_o, dmem_err_o, dmem_rdata_o,
    input  mem_valid_o, mem_addr_o, mem_wdata_o, mem_we_o,
    output mem_ready_i, mem_rdata_i
  );

endinterface

// File: rtl/mem_port_arbiter_timeout.sv
// arb_timeout_counter: counts BUSY cycles spent waiting for memory.
// expired_o is high while the count sits at TIMEOUT-1, i.e. on the TIMEOUT-th
// waiting cycle. TIMEOUT=0 disables the watchdog (expired_o is tied low).
module arb_timeout_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT = ARB_DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = arbCountWidth(TIMEOUT);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Clear while idle so every transaction starts at zero, otherwise count waits.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  generate
    if (TIMEOUT > 0) begin : g_watchdog
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
      assign expired_o = (count_q == LAST);
    end else begin : g_no_watchdog
      logic unusedCount;
      assign unusedCount = ^count_q;
      assign expired_o   = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch (I) and
// the LSU data port (D). The grant is registered (one arbitration slot in IDLE)
// and held until mem_ready_i or a timeout ends the transaction.
// Optional macro ARB_ROUND_ROBIN_EN: alternate grants when both request at once;
// without it D always wins over I.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = ARB_ADDR_WIDTH,
  parameter int DATA_WIDTH = ARB_DATA_WIDTH,
  parameter int TIMEOUT    = ARB_DEFAULT_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.slave   bus
);

  arb_state_e            state_q;
  arb_state_e            state_d;
  logic                  busyI;
  logic                  busyD;
  logic                  busy;
  logic                  expired;
  logic                  timeoutHit;
  logic [ADDR_WIDTH-1:0] addrMux;
  logic [DATA_WIDTH-1:0] wdataMux;
  logic [3:0]            weMux;

  assign busyI = (state_q == ARB_BUSY_I);
  assign busyD = (state_q == ARB_BUSY_D);
  assign busy  = busyI | busyD;

  // Ready wins over a same-cycle timeout, so the error only fires without ready.
  assign timeoutHit = busy & expired & ~bus.mem_ready_i;

  arb_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (~busy),
    .enable_i  (busy & ~bus.mem_ready_i),
    .expired_o (expired)
  );

`ifdef ARB_ROUND_ROBIN_EN
  arb_owner_e lastOwner_q;
  arb_owner_e lastOwner_d;

  // Remember who was granted last so a simultaneous request goes to the other.
  always_comb begin
    lastOwner_d = lastOwner_q;
    if (state_q == ARB_IDLE) begin
      if (state_d == ARB_BUSY_D) begin
        lastOwner_d = ARB_OWNER_D;
      end else if (state_d == ARB_BUSY_I) begin
        lastOwner_d = ARB_OWNER_I;
      end
    end
  end

  // History bit register; starts as I so the first contested grant goes to D.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lastOwner_q <= ARB_OWNER_I;
    end else begin
      lastOwner_q <= lastOwner_d;
    end
  end
`endif

  // Next-state logic: arbitrate in IDLE, return to IDLE on completion/timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: begin
`ifdef ARB_ROUND_ROBIN_EN
        if (bus.dmem_valid_i && bus.imem_valid_i) begin
          state_d = (lastOwner_q == ARB_OWNER_I) ? ARB_BUSY_D : ARB_BUSY_I;
        end else if (bus.dmem_valid_i) begin
          state_d = ARB_BUSY_D;
        end else if (bus.imem_valid_i) begin
          state_d = ARB_BUSY_I;
        end
`else
        if (bus.dmem_valid_i) begin
          state_d = ARB_BUSY_D;
        end else if (bus.imem_valid_i) begin
          state_d = ARB_BUSY_I;
        end
`endif
      end
      ARB_BUSY_I, ARB_BUSY_D: begin
        if (bus.mem_ready_i || timeoutHit) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State register; reset drops any transaction in flight without a pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Route the owner's request to memory; an I fetch never writes.
  always_comb begin
    addrMux  = '0;
    wdataMux = '0;
    weMux    = 4'h0;
    if (busyD) begin
      addrMux  = bus.dmem_addr_i;
      wdataMux = bus.dmem_wdata_i;
      weMux    = bus.dmem_we_i;
    end else if (busyI) begin
      addrMux  = bus.imem_addr_i;
    end
  end

  assign bus.mem_valid_o  = busy;
  assign bus.mem_addr_o   = addrMux;
  assign bus.mem_wdata_o  = wdataMux;
  assign bus.mem_we_o     = weMux;

  assign bus.imem_ready_o = busyI & bus.mem_ready_i;
  assign bus.dmem_ready_o = busyD & bus.mem_ready_i;
  assign bus.imem_err_o   = busyI & timeoutHit;
  assign bus.dmem_err_o   = busyD & timeoutHit;

  assign bus.imem_rdata_o = bus.mem_rdata_i;
  assign bus.dmem_rdata_o = bus.mem_rdata_i;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter built with TIMEOUT=4.
// Honours ARB_ROUND_ROBIN_EN for the contested-grant expectations.
module tb_mem_port_arbiter;

  logic clk;
  logic rst_n;

  mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  mem_port_arbiter #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .TIMEOUT    (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        iv;
    logic [31:0] ia;
    logic        dv;
    logic [31:0] da;
    logic [31:0] dw;
    logic [3:0]  dwe;
    logic        mr;
    logic [31:0] md;
    logic        ev;
    logic [31:0] ea;
    logic [31:0] ew;
    logic [3:0]  ewe;
    logic        eir;
    logic        eie;
    logic        edr;
    logic        ede;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(string name,
                              logic iv, logic [31:0] ia,
                              logic dv, logic [31:0] da, logic [31:0] dw, logic [3:0] dwe,
                              logic mr, logic [31:0] md,
                              logic ev, logic [31:0] ea, logic [31:0] ew, logic [3:0] ewe,
                              logic eir, logic eie, logic edr, logic ede);
    vec_t v;
    v.name = name; v.iv = iv; v.ia = ia; v.dv = dv; v.da = da; v.dw = dw; v.dwe = dwe;
    v.mr = mr; v.md = md; v.ev = ev; v.ea = ea; v.ew = ew; v.ewe = ewe;
    v.eir = eir; v.eie = eie; v.edr = edr; v.ede = ede;
    return v;
  endfunction

  task automatic check32(string what, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", what, act, exp);
    end
  endtask

  // Drive one cycle's inputs just after the rising edge.
  task automatic applyStimulus(vec_t v);
    @(posedge clk);
    #1;
    bus.imem_valid_i = v.iv;
    bus.imem_addr_i  = v.ia;
    bus.dmem_valid_i = v.dv;
    bus.dmem_addr_i  = v.da;
    bus.dmem_wdata_i = v.dw;
    bus.dmem_we_i    = v.dwe;
    bus.mem_ready_i  = v.mr;
    bus.mem_rdata_i  = v.md;
  endtask

  // Compare outputs mid-cycle on the falling edge.
  task automatic checkOutput(vec_t v);
    @(negedge clk);
    check32({v.name, ".mem_valid"},  {31'd0, bus.mem_valid_o},  {31'd0, v.ev});
    check32({v.name, ".mem_we"},     {28'd0, bus.mem_we_o},     {28'd0, v.ewe});
    check32({v.name, ".imem_ready"}, {31'd0, bus.imem_ready_o}, {31'd0, v.eir});
    check32({v.name, ".imem_err"},   {31'd0, bus.imem_err_o},   {31'd0, v.eie});
    check32({v.name, ".dmem_ready"}, {31'd0, bus.dmem_ready_o}, {31'd0, v.edr});
    check32({v.name, ".dmem_err"},   {31'd0, bus.dmem_err_o},   {31'd0, v.ede});
    check32({v.name, ".imem_rdata"}, bus.imem_rdata_o, v.md);
    check32({v.name, ".dmem_rdata"}, bus.dmem_rdata_o, v.md);
    if (v.ev) begin
      check32({v.name, ".mem_addr"},  bus.mem_addr_o,  v.ea);
      check32({v.name, ".mem_wdata"}, bus.mem_wdata_o, v.ew);
    end
  endtask

  // Protocol monitor: the owner must keep valid high for its whole transaction.
  logic busyPrev = 1'b0;
  logic monOwnerD = 1'b0;
  always @(negedge clk) begin
    if (rst_n && bus.mem_valid_o) begin
      if (!busyPrev) begin
        monOwnerD = bus.dmem_valid_i && (bus.mem_addr_o == bus.dmem_addr_i);
      end
      total++;
      if (monOwnerD ? !bus.dmem_valid_i : !bus.imem_valid_i) begin
        bad++;
        $display("[TB] FAIL owner_valid_held: owner valid got 0 expected 1 (ownerD=%0d)", monOwnerD);
      end
      busyPrev = !(bus.imem_ready_o || bus.dmem_ready_o || bus.imem_err_o || bus.dmem_err_o);
    end else begin
      busyPrev = 1'b0;
    end
  end

  localparam logic [31:0] Z = 32'h0;

  initial begin
    vec_t idleV;
    vec_t v;

    // Single I read, 3 wait cycles, data DEADBEEF.
    vecs.push_back(mk("A0", 1, 32'h100, 0, Z, Z, 4'h0, 0, Z,             0, Z, Z, 4'h0, 0, 0, 0, 0));
    vecs.push_back(mk("A1", 1, 32'h100, 0, Z, Z, 4'h0, 0, Z,             1, 32'h100, Z, 4'h0, 0, 0, 0, 0));
    vecs.push_back(mk("A2", 1, 32'h100, 0, Z, Z, 4'h0, 0, Z,             1, 32'h100, Z, 4'h0, 0, 0, 0, 0));
    vecs.push_back(mk("A3", 1, 32'h100, 0, Z, Z, 4'h0, 0, Z,             1, 32'h100, Z, 4'h0, 0, 0, 0, 0));
    vecs.push_back(mk("A4", 1, 32'h100, 0, Z, Z, 4'h0, 1, 32'hDEADBEEF,  1, 32'h100, Z, 4'h0, 1, 0, 0, 0));
    vecs.push_back(mk("A5", 0, Z,       0, Z, Z, 4'h0, 0, Z,             0, Z, Z, 4'h0, 0, 0, 0, 0));
    // Simultaneous D store and I fetch: D first, one bubble, then I.
    vecs.push_back(mk("B0", 1, 32'h104, 1, 32'h200, 32'hCAFEF00D, 4'hF, 0, Z, 0, Z, Z, 4'h0, 0, 0, 0, 0));
    vecs.push_back(mk("B1", 1, 32'h104, 1, 32'h200, 32'hCAFEF00D, 4'hF, 1, Z, 1, 32'h200, 32'hCAFEF00D, 4'hF, 0, 0, 1, 0));
    vecs.push_back(mk("B2", 1, 32'h104, 0, Z, Z, 4'h0, 0, Z,             0, Z, Z, 4'h0, 0, 0, 0, 0));
    vecs.push_back(mk("B3", 1, 32'h104, 0, Z, Z, 4'h0, 1, 32'h12345678,  1, 32'h104, Z, 4'h0, 1, 0, 0, 0));
    vecs.push_back(mk("B4", 0, Z,       0, Z, Z, 4'h0, 0, Z,             0, Z, Z, 4'h0, 0, 0, 0, 0));
    // Byte store with I pending, then the I fetch must not write.
    vecs.push_back(mk("S0", 1, 32'h108, 1, 32'h400, 32'h00AB0000, 4'b0100, 0, Z, 0, Z, Z, 4'h0, 0, 0, 0, 0));
    vecs.push_back(mk("S1", 1, 32'h108, 1, 32'h400, 32'h00AB0000, 4'b0100, 0, Z, 1, 32'h400, 32'h00AB0000, 4'b0100, 0, 0, 0, 0));
    vecs.push_back(mk("S2", 1, 32'h108, 1, 32'h400, 32'h00AB0000, 4'b0100, 1, 32'h55, 1, 32'h400, 32'h00AB0000, 4'b0100, 0, 0, 1, 0));
    vecs.push_back(mk("S3", 1, 32'h108, 0, Z, Z, 4'h0, 0, Z,             0, Z, Z, 4'h0, 0, 0, 0, 0));
    vecs.push_back(mk("S4", 1, 32'h108, 0, Z, Z, 4'h0, 1, 32'h66,        1, 32'h108, Z, 4'h0, 1, 0, 0, 0));
    vecs.push_back(mk("S5", 0, Z,       0, Z, Z, 4'h0, 0, Z,             0, Z, Z, 4'h0, 0, 0, 0, 0));
    // Continuous requests, zero wait states; ready in IDLE is ignored.
    vecs.push_back(mk("C0", 1, 32'h10C, 1, 32'h300, 32'h1234, 4'h3, 1, 32'h77, 0, Z, Z, 4'h0, 0, 0, 0, 0));
    vecs.push_back(mk("C1", 1, 32'h10C, 1, 32'h300, 32'h1234, 4'h3, 1, 32'h77, 1, 32'h300, 32'h1234, 4'h3, 0, 0, 1, 0));
    vecs.push_back(mk("C2", 1, 32'h10C, 1, 32'h300, 32'h1234, 4'h3, 1, 32'h77, 0, Z, Z, 4'h0, 0, 0, 0, 0));
`ifdef ARB_ROUND_ROBIN_EN
    vecs.push_back(mk("C3", 1, 32'h10C, 1, 32'h300, 32'h1234, 4'h3, 1, 32'h77, 1, 32'h10C, Z, 4'h0, 1, 0, 0, 0));
`else
    vecs.push_back(mk("C3", 1, 32'h10C, 1, 32'h300, 32'h1234, 4'h3, 1, 32'h77, 1, 32'h300, 32'h1234, 4'h3, 0, 0, 1, 0));
`endif
    vecs.push_back(mk("C4", 1, 32'h10C, 1, 32'h300, 32'h1234, 4'h3, 1, 32'h77, 0, Z, Z, 4'h0, 0, 0, 0, 0));
    vecs.push_back(mk("C5", 1, 32'h10C, 1, 32'h300, 32'h1234, 4'h3, 1, 32'h77, 1, 32'h300, 32'h1234, 4'h3, 0, 0, 1, 0));
    vecs.push_back(mk("C6", 0, Z,       0, Z, Z, 4'h0, 0, Z,             0, Z, Z, 4'h0, 0, 0, 0, 0));
    // Timeout (TIMEOUT=4): error on the 4th BUSY cycle, then ready wins on the 4th.
    vecs.push_back(mk("E0", 0, Z, 1, 32'h500, Z, 4'h0, 0, Z, 0, Z, Z, 4'h0, 0, 0, 0, 0));
    vecs.push_back(mk("E1", 0, Z, 1, 32'h500, Z, 4'h0, 0, Z, 1, 32'h500, Z, 4'h0, 0, 0, 0, 0));
    vecs.push_back(mk("E2", 0, Z, 1, 32'h500, Z, 4'h0, 0, Z, 1, 32'h500, Z, 4'h0, 0, 0, 0, 0));
    vecs.push_back(mk("E3", 0, Z, 1, 32'h500, Z, 4'h0, 0, Z, 1, 32'h500, Z, 4'h0, 0, 0, 0, 0));
    vecs.push_back(mk("E4", 0, Z, 1, 32'h500, Z, 4'h0, 0, Z, 1, 32'h500, Z, 4'h0, 0, 0, 0, 1));
    vecs.push_back(mk("E5", 0, Z, 0, Z,       Z, 4'h0, 0, Z, 0, Z, Z, 4'h0, 0, 0, 0, 0));
    vecs.push_back(mk("E6", 0, Z, 1, 32'h504, Z, 4'h0, 0, Z, 0, Z, Z, 4'h0, 0, 0, 0, 0));
    vecs.push_back(mk("E7", 0, Z, 1, 32'h504, Z, 4'h0, 0, Z, 1, 32'h504, Z, 4'h0, 0, 0, 0, 0));
    vecs.push_back(mk("E8", 0, Z, 1, 32'h504, Z, 4'h0, 0, Z, 1, 32'h504, Z, 4'h0, 0, 0, 0, 0));
    vecs.push_back(mk("E9", 0, Z, 1, 32'h504, Z, 4'h0, 0, Z, 1, 32'h504, Z, 4'h0, 0, 0, 0, 0));
    vecs.push_back(mk("E10", 0, Z, 1, 32'h504, Z, 4'h0, 1, 32'hA5A5A5A5, 1, 32'h504, Z, 4'h0, 0, 0, 1, 0));
    vecs.push_back(mk("E11", 0, Z, 0, Z,       Z, 4'h0, 0, Z, 0, Z, Z, 4'h0, 0, 0, 0, 0));

    idleV = mk("reset", 0, Z, 0, Z, Z, 4'h0, 0, Z, 0, Z, Z, 4'h0, 0, 0, 0, 0);

    // Reset state.
    rst_n            = 1'b0;
    bus.imem_valid_i = 1'b0;
    bus.imem_addr_i  = Z;
    bus.dmem_valid_i = 1'b0;
    bus.dmem_addr_i  = Z;
    bus.dmem_wdata_i = Z;
    bus.dmem_we_i    = 4'h0;
    bus.mem_ready_i  = 1'b0;
    bus.mem_rdata_i  = Z;
    checkOutput(idleV);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Main directed table.
    for (int k = 0; k < vecs.size(); k++) begin
      applyStimulus(vecs[k]);
      checkOutput(vecs[k]);
    end

    // Asynchronous reset while D owns the port.
    v = mk("R0", 0, Z, 1, 32'h600, 32'hFFFF0000, 4'hF, 0, Z, 0, Z, Z, 4'h0, 0, 0, 0, 0);
    applyStimulus(v);
    checkOutput(v);
    v = mk("R1", 0, Z, 1, 32'h600, 32'hFFFF0000, 4'hF, 0, Z, 1, 32'h600, 32'hFFFF0000, 4'hF, 0, 0, 0, 0);
    applyStimulus(v);
    checkOutput(v);
    #2 rst_n = 1'b0;
    #1;
    check32("R2.mem_valid_async", {31'd0, bus.mem_valid_o}, 32'd0);
    check32("R2.mem_we_async",    {28'd0, bus.mem_we_o},    32'd0);
    check32("R2.dmem_ready",      {31'd0, bus.dmem_ready_o}, 32'd0);
    check32("R2.dmem_err",        {31'd0, bus.dmem_err_o},   32'd0);
    bus.dmem_valid_i = 1'b0;
    bus.dmem_addr_i  = Z;
    bus.dmem_wdata_i = Z;
    bus.dmem_we_i    = 4'h0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    v = mk("R3", 0, Z, 0, Z, Z, 4'h0, 0, Z, 0, Z, Z, 4'h0, 0, 0, 0, 0);
    checkOutput(v);

    // Fresh I request after the reset is granted normally.
    v = mk("F0", 1, 32'h110, 0, Z, Z, 4'h0, 0, Z, 0, Z, Z, 4'h0, 0, 0, 0, 0);
    applyStimulus(v);
    checkOutput(v);
    v = mk("F1", 1, 32'h110, 0, Z, Z, 4'h0, 1, 32'h0000BEEF, 1, 32'h110, Z, 4'h0, 1, 0, 0, 0);
    applyStimulus(v);
    checkOutput(v);
    v = mk("F2", 0, Z, 0, Z, Z, 4'h0, 0, Z, 0, Z, Z, 4'h0, 0, 0, 0, 0);
    applyStimulus(v);
    checkOutput(v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single core-side memory port between two requesters: the instruction fetch port (I) and the load/store unit data port (D).
- Registered grant with a one-cycle arbitration slot. Holds the grant for the whole transaction, which ends on mem_ready_i or on a timeout.
- Sits between fetch/LSU and the unified memory/bus. Requester signals use valid/ready, with ready as a single-cycle completion pulse.

Parameters:
- ADDR_WIDTH, 32, address width (matches RISCV_ADDR_WIDTH)
- DATA_WIDTH, 32, data width (matches RISCV_WORD_WIDTH)
- TIMEOUT, 255, maximum BUSY cycles waiting for mem_ready_i; 0 disables the timeout

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active low
- imem_valid_i  in  1  fetch request; held with addr stable until imem_ready_o or imem_err_o
- imem_addr_i  in  ADDR_WIDTH  fetch address
- imem_ready_o  out  1  fetch completion pulse; imem_rdata_o valid this cycle
- imem_err_o  out  1  fetch timeout pulse
- imem_rdata_o  out  DATA_WIDTH  fetch read data
- dmem_valid_i  in  1  LSU request; held with addr/wdata/we stable until done
- dmem_addr_i  in  ADDR_WIDTH  LSU address
- dmem_wdata_i  in  DATA_WIDTH  LSU write data, already lane-aligned
- dmem_we_i  in  4  LSU byte write enables; 0 means read
- dmem_ready_o  out  1  LSU completion pulse
- dmem_err_o  out  1  LSU timeout pulse
- dmem_rdata_o  out  DATA_WIDTH  LSU read data
- mem_valid_o  out  1  memory request
- mem_ready_i  in  1  memory completion
- mem_addr_o  out  ADDR_WIDTH  memory address
- mem_wdata_o  out  DATA_WIDTH  memory write data
- mem_we_o  out  4  memory byte write enables
- mem_rdata_i  in  DATA_WIDTH  memory read data

Behaviour:
- Clock and reset: clk, rst_n; reset is asynchronous, active low.
- Reset values: state IDLE, owner NONE, timeout counter 0. mem_valid_o, mem_we_o, imem_ready_o, dmem_ready_o, imem_err_o and dmem_err_o are all 0.
- State machine: IDLE, BUSY_I, BUSY_D.
- IDLE: if dmem_valid_i then BUSY_D, else if imem_valid_i then BUSY_I (fixed priority D>I). Otherwise stay in IDLE. No memory outputs are asserted in IDLE.
- BUSY_x:
  - mem_valid_o=1.
  - mem_addr_o, mem_wdata_o and mem_we_o are muxed combinationally from the owner's inputs. For I: mem_we_o=0, mem_wdata_o=0.
  - The non-owner's ready/err are held at 0.
- Completion: mem_ready_i=1 in BUSY_x gives x_ready_o=1 that same cycle, combinationally gated by owner. Next state is IDLE.
- Throughput: one idle bubble between transactions. Minimum latency from valid to ready is 2 cycles when memory has zero wait states.
- Read data: imem_rdata_o and dmem_rdata_o both carry mem_rdata_i unconditionally. Consumers sample it only on their ready.
- Timeout counter:
  - Clears on entry to BUSY and increments every BUSY cycle without mem_ready_i.
  - When it reaches TIMEOUT-1 with no ready: x_err_o=1 for one cycle, x_ready_o=0, next state IDLE, mem_valid_o dropped.
  - mem_ready_i in the same cycle as the timeout wins: report completion, no error.
  - Counter width is clog2(TIMEOUT+1).
- Simultaneous requests in IDLE: D is granted. I waits and stays asserted; it is granted after D completes, unless D requests again (starvation possible under fixed priority).
- Requester drops valid while owning the grant: protocol violation. The transaction still runs to completion and the ready pulse is still issued. The bench asserts that this never happens.
- mem_ready_i in IDLE: ignored.
- Reset mid-transaction: immediate return to IDLE with all outputs at reset values. No ready or err pulse is issued.

Optional Feature:
- ARB_ROUND_ROBIN_EN defined:
  - Adds a 1-bit last_owner register, reset value I.
  - When both requesters are valid in IDLE, the requester that was not last_owner is granted.
  - A single requester is granted regardless of last_owner.
  - last_owner updates on every grant.
- ARB_ROUND_ROBIN_EN undefined: fixed priority D>I; the register is absent.

Decomposition:
- Shared package/defines (alongside riscv_defines):
  - state encodings ARB_IDLE=2'd0, ARB_BUSY_I=2'd1, ARB_BUSY_D=2'd2
  - owner encodings ARB_OWNER_I/ARB_OWNER_D
  - default TIMEOUT constant
- One natural sub-module: arb_timeout_counter (clear, enable, parameter TIMEOUT, expired output). The FSM and output muxing stay in the top.

Test Plan:
- Single I read at 0x0000_0100, memory ready after 3 wait cycles, rdata 0xDEAD_BEEF:
  - mem_valid_o rises 1 cycle after imem_valid_i.
  - imem_ready_o pulses once with imem_rdata_o=0xDEAD_BEEF.
  - dmem_ready_o stays 0.
- D and I valid in the same cycle (D: sw 0xCAFE_F00D to 0x0000_0200, we=4'hF):
  - D is granted first; mem_we_o=4'hF, mem_wdata_o=0xCAFE_F00D.
  - After dmem_ready_o, there is one IDLE cycle, then I is granted.
- Continuous D and I requests, each completing with zero wait states:
  - Fixed priority: grants D,D,D…
  - With ARB_ROUND_ROBIN_EN: grants D,I,D,I.
- TIMEOUT=4, memory never ready:
  - dmem_err_o pulses on the 4th BUSY cycle, and mem_valid_o deasserts the next cycle.
  - With mem_ready_i asserted on that same 4th cycle: ready pulse instead of err.
- rst_n asserted during BUSY_D (mem_valid_o=1):
  - mem_valid_o=0 immediately, asynchronously.
  - No ready or err pulse is issued.
  - After release, a fresh I request is granted normally.
- Byte store (we=4'b0100, wdata=0x00AB_0000) while I is also pending:
  - mem_we_o=4'b0100 and mem_wdata_o unchanged from the LSU's values.
  - mem_we_o=0 during the following I transaction.
